cnn_pixel_frame_receiver: RTL

CNN-side consumer of the single-cycle pixel pulse interface (frame_start, pixel_valid + pixel_data, frame_complete) produced by the AXI control block under MicroBlaze control. Assembles one frame into the CNN input buffer through a registered write port and checks frame length. Hands the completed frame to the CNN core with a ready/ack handshake. Returns busy, error and frame-count status for the AXI status registers.

---
 rtl/cnn_pixel_frame_receiver_if.sv | 29 ++
 rtl/cnn_pixel_frame_receiver.sv | 120 ++++++++++++
 2 files changed

// File: rtl/cnn_pixel_frame_receiver_if.sv
// cnn_pixel_frame_receiver_if: pixel pulse input, buffer write port, CNN handshake and status bundle
interface cnn_pixel_frame_receiver_if #(parameter int ADDR_W = 10);
  logic              soft_reset;
  logic              frame_start;
  logic              pixel_valid;
  logic [7:0]        pixel_data;
  logic              frame_complete;
  logic              frame_ack;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_wdata;
  logic              frame_ready;
  logic              busy;
  logic [ADDR_W:0]   pixel_count;
  logic [ADDR_W-1:0] cur_row;
  logic [ADDR_W-1:0] cur_col;
  logic [3:0]        err_code;
  logic [31:0]       frame_count;
  modport slave (
    input  soft_reset, frame_start, pixel_valid, pixel_data, frame_complete, frame_ack,
    output buf_we, buf_addr, buf_wdata, frame_ready, busy, pixel_count, cur_row, cur_col,
           err_code, frame_count
  );
  modport master (
    output soft_reset, frame_start, pixel_valid, pixel_data, frame_complete, frame_ack,
    input  buf_we, buf_addr, buf_wdata, frame_ready, busy, pixel_count, cur_row, cur_col,
           err_code, frame_count
  );
endinterface

// File: rtl/cnn_pixel_frame_receiver.sv
// cnn_pixel_frame_receiver: assembles one pixel frame into the CNN buffer, checks its length
// and hands it to the CNN core with a ready/ack handshake.
module cnn_pixel_frame_receiver #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10
) (
  input logic clk,
  input logic rst_n,
  cnn_pixel_frame_receiver_if.slave pix
);
  typedef enum logic [1:0] {IDLE, RECV, WAIT_ACK} state_t;
  localparam logic [ADDR_W:0]   TOTAL    = (ADDR_W+1)'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d, addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [3:0]        err_q, err_d;
  logic [31:0]       fcnt_q, fcnt_d;
  logic              we_q, we_d, rdy_q, rdy_d, acc;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    fcnt_d  = fcnt_q;
    we_d    = 1'b0;
    acc     = 1'b0;
    if (pix.soft_reset) begin
      state_d = IDLE;
      cnt_d   = '0;
      row_d   = '0;
      col_d   = '0;
      err_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pix.frame_start) begin
            state_d = RECV;
            cnt_d   = '0;
            row_d   = '0;
            col_d   = '0;
          end else if (pix.pixel_valid || pix.frame_complete) err_d[0] = 1'b1;
        end
        RECV: begin
          if (pix.frame_start) begin
            err_d[3] = 1'b1;
            cnt_d    = '0;
            row_d    = '0;
            col_d    = '0;
          end else begin
            acc = pix.pixel_valid && (cnt_q < TOTAL);
            if (pix.pixel_valid && !acc) err_d[1] = 1'b1;
            if (acc) begin
              we_d    = 1'b1;
              addr_d  = cnt_q[ADDR_W-1:0];
              wdata_d = pix.pixel_data;
              cnt_d   = cnt_q + 1'b1;
              col_d   = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
              row_d   = (col_q == LAST_COL) ? row_q + 1'b1 : row_q;
            end
            // cnt_d already includes a pixel arriving alongside frame_complete
            if (pix.frame_complete) begin
              state_d = (cnt_d == TOTAL) ? WAIT_ACK : IDLE;
              if (cnt_d != TOTAL) err_d[2] = 1'b1;
            end
          end
        end
        WAIT_ACK: begin
          if (pix.frame_ack) begin
            state_d = IDLE;
            fcnt_d  = fcnt_q + 1'b1;
          end
          if (pix.pixel_valid || pix.frame_start) err_d[0] = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    rdy_d = (state_d == WAIT_ACK);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= '0;
      fcnt_q  <= '0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
    end
  end
  assign pix.buf_we      = we_q;
  assign pix.buf_addr    = addr_q;
  assign pix.buf_wdata   = wdata_q;
  assign pix.frame_ready = rdy_q;
  assign pix.busy        = (state_q != IDLE);
  assign pix.pixel_count = cnt_q;
  assign pix.cur_row     = row_q;
  assign pix.cur_col     = col_q;
  assign pix.err_code    = err_q;
  assign pix.frame_count = fcnt_q;
endmodule
